// File: rtl/cu_pkg.sv
// Shared types and constants for the control-unit fetch path.
package cu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [3:0]  BE_WORD    = 4'b1111;
    localparam logic        MEM_READ   = 1'b0;

endpackage

// File: rtl/cu_fetch_pc_gen.sv
// Program-counter owner and word-fetch request generator feeding CU_IF.
// Issues one read per instruction, tracks completion/timeout, applies
// branch redirects and hands completed, non-squashed PCs to decode.
module cu_fetch_pc_gen
    import cu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic        soc_clk,
    input  logic        IF_reset,
    input  logic        IF_poweron,
    input  logic        IF_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        fetch_done,
    output logic        memfetch_start,
    output logic [31:0] addr,
    output logic [3:0]  bits_to_access,
    output logic        read_or_write,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic        misalign_err,
    output logic [3:0]  timeout_cnt
);

    // Wait counter runs 0..TIMEOUT_CYC-1 across the WAIT cycles.
    localparam int unsigned      CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             redir_pend_q, redir_pend_d;
    logic [31:0]      redir_addr_q, redir_addr_d;
    logic             squash_q, squash_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]       timeout_cnt_q, timeout_cnt_d;
    logic             misalign_err_q, misalign_err_d;
    logic             instr_valid_q, instr_valid_d;
    logic [31:0]      pc_out_q, pc_out_d;
    logic             memfetch_start_q, memfetch_start_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       bte_q, bte_d;

    logic go;
    logic redir_ok;
    logic redir_bad;

    assign go        = IF_poweron && !IF_stall;
    assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

    // Next-state, PC update, redirect bookkeeping and registered-output staging.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        redir_pend_d   = redir_pend_q;
        redir_addr_d   = redir_addr_q;
        squash_d       = squash_q;
        halt_pend_d    = halt_pend_q;
        wait_cnt_d     = wait_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        misalign_err_d = misalign_err_q;
        instr_valid_d  = 1'b0;
        pc_out_d       = pc_out_q;

        unique case (state_q)
            IDLE: begin
                if (redir_bad) begin
                    misalign_err_d = 1'b1;
                    state_d        = HALT;
                end else begin
                    if (redir_ok) begin
                        pc_d = redirect_target;
                    end
                    if (go) begin
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
                if (redir_ok) begin
                    redir_pend_d = 1'b1;
                    redir_addr_d = redirect_target;
                    squash_d     = 1'b1;
                end else if (redir_bad) begin
                    misalign_err_d = 1'b1;
                    halt_pend_d    = 1'b1;
                    squash_d       = 1'b1;
                end
            end

            WAIT: begin
                if (fetch_done) begin
                    // A redirect coinciding with completion squashes and applies now.
                    instr_valid_d = !(squash_q || redirect_valid);
                    pc_out_d      = pc_q;
                    if (halt_pend_q || redir_bad) begin
                        misalign_err_d = misalign_err_q || redir_bad;
                        state_d        = HALT;
                    end else begin
                        if (redir_ok) begin
                            pc_d = redirect_target;
                        end else if (redir_pend_q) begin
                            pc_d = redir_addr_q;
                        end else begin
                            pc_d = pc_q + WORD_BYTES;
                        end
                        state_d = go ? ISSUE : IDLE;
                    end
                    redir_pend_d = 1'b0;
                    squash_d     = 1'b0;
                    halt_pend_d  = 1'b0;
                end else begin
                    if (redir_ok) begin
                        redir_pend_d = 1'b1;
                        redir_addr_d = redirect_target;
                        squash_d     = 1'b1;
                    end else if (redir_bad) begin
                        misalign_err_d = 1'b1;
                        halt_pend_d    = 1'b1;
                        squash_d       = 1'b1;
                    end
                    if (wait_cnt_q == CNT_LAST) begin
                        // Timed-out drain of a misaligned redirect halts instead of re-issuing.
                        if (halt_pend_d) begin
                            state_d      = HALT;
                            redir_pend_d = 1'b0;
                            squash_d     = 1'b0;
                            halt_pend_d  = 1'b0;
                        end else begin
                            state_d = ISSUE;
                            if (timeout_cnt_q != 4'hF) begin
                                timeout_cnt_d = timeout_cnt_q + 4'd1;
                            end
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        memfetch_start_d = (state_d == ISSUE);
        addr_d           = pc_d;
        bte_d            = ((state_d == ISSUE) || (state_d == WAIT)) ? BE_WORD : '0;
    end

    // State and output registers, asynchronously reset.
    always_ff @(posedge soc_clk or posedge IF_reset) begin
        if (IF_reset) begin
            state_q          <= IDLE;
            pc_q             <= RESET_PC;
            redir_pend_q     <= 1'b0;
            redir_addr_q     <= RESET_PC;
            squash_q         <= 1'b0;
            halt_pend_q      <= 1'b0;
            wait_cnt_q       <= '0;
            timeout_cnt_q    <= '0;
            misalign_err_q   <= 1'b0;
            instr_valid_q    <= 1'b0;
            pc_out_q         <= RESET_PC;
            memfetch_start_q <= 1'b0;
            addr_q           <= RESET_PC;
            bte_q            <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            redir_pend_q     <= redir_pend_d;
            redir_addr_q     <= redir_addr_d;
            squash_q         <= squash_d;
            halt_pend_q      <= halt_pend_d;
            wait_cnt_q       <= wait_cnt_d;
            timeout_cnt_q    <= timeout_cnt_d;
            misalign_err_q   <= misalign_err_d;
            instr_valid_q    <= instr_valid_d;
            pc_out_q         <= pc_out_d;
            memfetch_start_q <= memfetch_start_d;
            addr_q           <= addr_d;
            bte_q            <= bte_d;
        end
    end

    assign memfetch_start = memfetch_start_q;
    assign addr           = addr_q;
    assign bits_to_access = bte_q;
    assign read_or_write  = MEM_READ;
    assign instr_valid    = instr_valid_q;
    assign pc_out         = pc_out_q;
    assign misalign_err   = misalign_err_q;
    assign timeout_cnt    = timeout_cnt_q;

endmodule
